mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the two-requester cache line-fill arbiter.
package mem_arbiter_pkg;

    localparam int LineSize = 128;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // 0 = instruction cache, 1 = data cache
    typedef logic req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the line-fill arbiter.
interface mem_arbiter_if #(
    parameter int LineSize = mem_arbiter_pkg::LineSize
);

    logic                req0_read_en_i;
    logic                req1_read_en_i;
    logic [31:0]         req0_addr_i;
    logic [31:0]         req1_addr_i;
    logic                req0_read_valid_o;
    logic                req1_read_valid_o;
    logic [LineSize-1:0] req_read_data_o;
    logic                mem_read_en_o;
    logic [31:0]         mem_addr_o;
    logic                mem_read_valid_i;
    logic [LineSize-1:0] mem_read_data_i;
    logic                timeout_o;
    logic                busy_o;

    // The arbiter itself sits on the slave side.
    modport slave (
        input  req0_read_en_i, req1_read_en_i, req0_addr_i, req1_addr_i,
        input  mem_read_valid_i, mem_read_data_i,
        output req0_read_valid_o, req1_read_valid_o, req_read_data_o,
        output mem_read_en_o, mem_addr_o, timeout_o, busy_o
    );

    modport master (
        output req0_read_en_i, req1_read_en_i, req0_addr_i, req1_addr_i,
        output mem_read_valid_i, mem_read_data_i,
        input  req0_read_valid_o, req1_read_valid_o, req_read_data_o,
        input  mem_read_en_o, mem_addr_o, timeout_o, busy_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two cache refill requesters a single
// outstanding downstream line read, with a cycle-count abort.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LineSize      = mem_arbiter_pkg::LineSize,
    parameter int TimeoutCycles = 255
) (
    input logic          clk_i,
    input logic          rst_i,
    mem_arbiter_if.slave bus
);

    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    state_t              state_q, state_d;
    req_id_t             owner_q;
    req_id_t             last_q;
    req_id_t             grant_id;
    logic [15:0]         cnt_q;
    logic [31:0]         addr_q;
    logic                grant;
    logic                resp;
    logic                tmo;
    logic [LineSize-1:0] fill_data;

    // Both requesters pending: alternate away from whoever was served last.
    function automatic req_id_t rr_pick(input logic r0, input logic r1, input req_id_t last);
        if (r0 && r1) begin
            return ~last;
        end else if (r0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_id = owner_q;
        resp     = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_read_en_i || bus.req1_read_en_i) begin
                    grant    = 1'b1;
                    grant_id = rr_pick(bus.req0_read_en_i, bus.req1_read_en_i, last_q);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // A response landing on the final allowed cycle still completes normally.
                if (bus.mem_read_valid_i) begin
                    resp    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TimeoutLast) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_id;
                addr_q  <= grant_id ? bus.req1_addr_i : bus.req0_addr_i;
                cnt_q   <= 16'd0;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (resp || tmo) begin
                last_q <= owner_q;
            end
        end
    end

    // Status pulses are masked during reset so nothing leaks from a stale BUSY.
    assign fill_data             = bus.mem_read_data_i;
    assign bus.req_read_data_o   = fill_data;
    assign bus.mem_addr_o        = addr_q;
    assign bus.busy_o            = (state_q == BUSY) && !rst_i;
    assign bus.mem_read_en_o     = (state_q == BUSY) && !rst_i;
    assign bus.req0_read_valid_o = resp && (owner_q == 1'b0) && !rst_i;
    assign bus.req1_read_valid_o = resp && (owner_q == 1'b1) && !rst_i;
    assign bus.timeout_o         = tmo && !rst_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued as the
// memory response (or its absence) is driven, and popped on each DUT pulse.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LineSize(LW)) bus ();

    mem_arbiter #(
        .LineSize     (LW),
        .TimeoutCycles(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef enum logic [1:0] {K_FILL0, K_FILL1, K_TMO} kind_t;
    typedef struct packed {
        kind_t         kind;
        logic [31:0]   addr;
        logic [LW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every valid/timeout pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.req0_read_valid_o || bus.req1_read_valid_o || bus.timeout_o) begin
            if (sb.size() == 0) begin
                check("spurious_pulse",
                      LW'({bus.req0_read_valid_o, bus.req1_read_valid_o, bus.timeout_o}), LW'(0));
            end else begin
                mon_e = sb.pop_front();
                check("rv0", LW'(bus.req0_read_valid_o), LW'(mon_e.kind == K_FILL0));
                check("rv1", LW'(bus.req1_read_valid_o), LW'(mon_e.kind == K_FILL1));
                check("timeout", LW'(bus.timeout_o), LW'(mon_e.kind == K_TMO));
                check("resp_addr", LW'(bus.mem_addr_o), LW'(mon_e.addr));
                if (mon_e.kind != K_TMO) check("resp_data", bus.req_read_data_o, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_read_en_i   = 1'b0;
        bus.req1_read_en_i   = 1'b0;
        bus.req0_addr_i      = 32'd0;
        bus.req1_addr_i      = 32'd0;
        bus.mem_read_valid_i = 1'b0;
        bus.mem_read_data_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        @(negedge clk);
        check("rst_addr", LW'(bus.mem_addr_o), LW'(0));
        check("rst_busy", LW'(bus.busy_o), LW'(0));
        rst = 1'b0;
        tick();
    endtask

    // Entered in the IDLE grant cycle; returns in the IDLE cycle after completion.
    task automatic transact(input int own, input logic [31:0] addr, input int lat,
                            input logic [LW-1:0] data, input bit drop, input bit chg);
        exp_t e;
        @(negedge clk);
        check("dwell_busy", LW'(bus.busy_o), LW'(0));
        check("dwell_rd_en", LW'(bus.mem_read_en_o), LW'(0));
        tick();
        @(negedge clk);
        check("busy", LW'(bus.busy_o), LW'(1));
        check("rd_en", LW'(bus.mem_read_en_o), LW'(1));
        check("grant_addr", LW'(bus.mem_addr_o), LW'(addr));
        if (drop) begin
            if (own == 0) bus.req0_read_en_i = 1'b0;
            else          bus.req1_read_en_i = 1'b0;
        end
        if (chg) begin
            if (own == 0) bus.req0_addr_i = addr + 32'h1000;
            else          bus.req1_addr_i = addr + 32'h1000;
        end
        for (int i = 0; i < lat; i++) begin
            tick();
            @(negedge clk);
            check("addr_hold", LW'(bus.mem_addr_o), LW'(addr));
            check("busy_hold", LW'(bus.busy_o), LW'(1));
        end
        tick();
        bus.mem_read_valid_i = 1'b1;
        bus.mem_read_data_i  = data;
        e.kind = (own == 0) ? K_FILL0 : K_FILL1;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
        @(negedge clk);
        check("data_pass", bus.req_read_data_o, data);
        tick();
        bus.mem_read_valid_i = 1'b0;
        bus.mem_read_data_i  = ~data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t te;
        logic [LW-1:0] d;

        // Outputs held low while reset is asserted, whatever the inputs do.
        clear_inputs();
        rst = 1'b1;
        bus.req0_read_en_i   = 1'b1;
        bus.req1_read_en_i   = 1'b1;
        bus.mem_read_valid_i = 1'b1;
        tick();
        @(negedge clk);
        check("rsthi_busy", LW'(bus.busy_o), LW'(0));
        check("rsthi_rd_en", LW'(bus.mem_read_en_o), LW'(0));
        check("rsthi_rv", LW'({bus.req0_read_valid_o, bus.req1_read_valid_o}), LW'(0));
        check("rsthi_tmo", LW'(bus.timeout_o), LW'(0));
        do_reset();

        // Single request, response on the last allowed BUSY cycle.
        bus.req0_read_en_i = 1'b1;
        bus.req0_addr_i    = 32'h0000_1230;
        d = {$urandom, $urandom, $urandom, $urandom};
        transact(0, 32'h0000_1230, 2, d, 1'b0, 1'b0);
        bus.req0_read_en_i = 1'b0;
        @(negedge clk);
        check("t1_busy_fall", LW'(bus.busy_o), LW'(0));
        tick();
        @(negedge clk);
        check("t1_stay_idle", LW'(bus.busy_o), LW'(0));
        check("t1_addr_kept", LW'(bus.mem_addr_o), LW'(32'h0000_1230));

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        bus.req0_read_en_i = 1'b1;
        bus.req1_read_en_i = 1'b1;
        bus.req0_addr_i    = 32'h0000_0100;
        bus.req1_addr_i    = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            transact(i % 2, (i % 2) ? 32'h0000_0200 : 32'h0000_0100, i % 3, d, 1'b0, 1'b0);
        end
        bus.req0_read_en_i = 1'b0;
        bus.req1_read_en_i = 1'b0;

        // Latched address survives a requester address change mid-BUSY.
        do_reset();
        bus.req1_read_en_i = 1'b1;
        bus.req1_addr_i    = 32'h0000_4000;
        d = {$urandom, $urandom, $urandom, $urandom};
        transact(1, 32'h0000_4000, 2, d, 1'b0, 1'b1);
        bus.req1_read_en_i = 1'b0;

        // Timeout after four silent BUSY cycles, then round-robin moves to requester 1.
        do_reset();
        bus.req0_read_en_i = 1'b1;
        bus.req0_addr_i    = 32'h0000_8000;
        te.kind = K_TMO;
        te.addr = 32'h0000_8000;
        te.data = '0;
        sb.push_back(te);
        @(negedge clk);
        tick();
        bus.req0_read_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tmo_busy", LW'(bus.busy_o), LW'(1));
            tick();
        end
        @(negedge clk);
        check("tmo_busy_fall", LW'(bus.busy_o), LW'(0));
        check("tmo_seen", LW'(sb.size()), LW'(0));
        repeat (3) tick();
        bus.req0_read_en_i = 1'b1;
        bus.req1_read_en_i = 1'b1;
        bus.req0_addr_i    = 32'h0000_0A00;
        bus.req1_addr_i    = 32'h0000_0B00;
        d = {$urandom, $urandom, $urandom, $urandom};
        transact(1, 32'h0000_0B00, 0, d, 1'b0, 1'b0);
        bus.req0_read_en_i = 1'b0;
        bus.req1_read_en_i = 1'b0;

        // Spurious response in IDLE, then a late response after a mid-BUSY reset.
        do_reset();
        bus.mem_read_valid_i = 1'b1;
        @(negedge clk);
        check("idle_rv", LW'({bus.req0_read_valid_o, bus.req1_read_valid_o}), LW'(0));
        tick();
        bus.mem_read_valid_i = 1'b0;
        bus.req0_read_en_i   = 1'b1;
        bus.req0_addr_i      = 32'h0000_9000;
        tick();
        @(negedge clk);
        check("mid_busy", LW'(bus.busy_o), LW'(1));
        tick();
        rst = 1'b1;
        bus.req0_read_en_i   = 1'b0;
        bus.mem_read_valid_i = 1'b1;
        @(negedge clk);
        check("mid_rst_rv", LW'({bus.req0_read_valid_o, bus.req1_read_valid_o}), LW'(0));
        check("mid_rst_busy", LW'(bus.busy_o), LW'(0));
        tick();
        rst = 1'b0;
        bus.mem_read_valid_i = 1'b0;
        @(negedge clk);
        check("mid_rst_addr", LW'(bus.mem_addr_o), LW'(0));
        tick();
        bus.mem_read_valid_i = 1'b1;
        @(negedge clk);
        check("late_rv", LW'({bus.req0_read_valid_o, bus.req1_read_valid_o}), LW'(0));
        check("late_busy", LW'(bus.busy_o), LW'(0));
        tick();
        bus.mem_read_valid_i = 1'b0;

        // Owner drops its request mid-BUSY; pending requester 1 follows after the dwell.
        do_reset();
        bus.req0_read_en_i = 1'b1;
        bus.req1_read_en_i = 1'b1;
        bus.req0_addr_i    = 32'h0000_0700;
        bus.req1_addr_i    = 32'h0000_0800;
        d = {$urandom, $urandom, $urandom, $urandom};
        transact(0, 32'h0000_0700, 1, d, 1'b1, 1'b0);
        d = {$urandom, $urandom, $urandom, $urandom};
        transact(1, 32'h0000_0800, 0, d, 1'b0, 1'b0);
        bus.req1_read_en_i = 1'b0;

        repeat (4) tick();
        check("sb_empty", LW'(sb.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
